// File: rtl/vga_sync_if.sv
// Sync-in / recovered-position bundle between a VGA timing source and vga_sync_receiver.
// Defining VGA_RX_MEASURE_EN adds the measurement signals meas_hpix, meas_vlines and err_cnt.
interface vga_sync_if #(
    parameter int unsigned pA = 10,
    parameter int unsigned fA = 32
);
    logic          hs;
    logic          vs;
    logic [pA-1:0] pix_x;
    logic [pA-1:0] pix_y;
    logic          pix_v;
    logic [fA-1:0] frame_id;
    logic          lock;
`ifdef VGA_RX_MEASURE_EN
    logic [pA-1:0] meas_hpix;
    logic [pA-1:0] meas_vlines;
    logic [15:0]   err_cnt;

    modport master (output hs, vs,
                    input  pix_x, pix_y, pix_v, frame_id, lock, meas_hpix, meas_vlines, err_cnt);
    modport slave  (input  hs, vs,
                    output pix_x, pix_y, pix_v, frame_id, lock, meas_hpix, meas_vlines, err_cnt);
`else
    modport master (output hs, vs,
                    input  pix_x, pix_y, pix_v, frame_id, lock);
    modport slave  (input  hs, vs,
                    output pix_x, pix_y, pix_v, frame_id, lock);
`endif
endinterface

// File: rtl/vga_sync_receiver.sv
// Recovers pixel/line position from active-low hs/vs, checks geometry and declares lock.
// Optional VGA_RX_MEASURE_EN adds measured line/frame lengths and a lock-loss counter.
module vga_sync_receiver #(
    parameter int unsigned pA          = 10,
    parameter int unsigned fA          = 32,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned HBP         = 48,
    parameter int unsigned HFP         = 16,
    parameter int unsigned HPW         = 96,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned VBP         = 33,
    parameter int unsigned VFP         = 10,
    parameter int unsigned VPW         = 2,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input logic       clk,
    input logic       rst,
    vga_sync_if.slave bus
);
    localparam int unsigned HTOTAL = H_ACTIVE + HBP + HFP + HPW;
    localparam int unsigned VTOTAL = V_ACTIVE + VBP + VFP + VPW;
    localparam int unsigned GW     = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t        state;
    logic          hs_d1;
    logic          vs_d1;
    logic [pA-1:0] cx;
    logic [pA-1:0] cy;
    logic [GW-1:0] good_cnt;

    logic hrise;
    logic vrise;
    logic cx_end;
    logic cy_end;
    logic bad_line;
    logic bad_frame;
    logic err;
    logic lock_nxt;
    logic in_win;

    // Rising edge of a sync = end of its pulse = start of line/frame.
    assign hrise  = bus.hs & ~hs_d1;
    assign vrise  = bus.vs & ~vs_d1;
    assign cx_end = (cx == pA'(HTOTAL - 1));
    assign cy_end = (cy == pA'(VTOTAL - 1));

    assign bad_line  = (hrise & ~cx_end) | (cx_end & ~hrise);
    assign bad_frame = (vrise & (~hrise | ~cy_end)) | (hrise & cy_end & ~vrise);
    assign err       = bad_line | bad_frame;

    // Mirrors the FSM's next state so lock and pix_v move on the deciding edge.
    assign lock_nxt = ~err & ((state == LOCKED) |
                              ((state == ALIGN) & vrise & (good_cnt == GW'(LOCK_FRAMES - 1))));

    assign in_win = (cx >= pA'(HBP)) && (cx < pA'(HBP + H_ACTIVE)) &&
                    (cy >= pA'(VBP)) && (cy < pA'(VBP + V_ACTIVE));

    // Position counters; reset syncs to high so no edge is seen coming out of reset.
    always_ff @(posedge clk or posedge rst) begin : counters
        if (rst) begin
            hs_d1 <= 1'b1;
            vs_d1 <= 1'b1;
            cx    <= '0;
            cy    <= '0;
        end else begin
            hs_d1 <= bus.hs;
            vs_d1 <= bus.vs;
            if (hrise || cx_end) cx <= '0;
            else                 cx <= cx + pA'(1);
            if (vrise)      cy <= '0;
            else if (hrise) cy <= cy_end ? '0 : cy + pA'(1);
        end
    end

    // Lock FSM with registered position/lock outputs.
    always_ff @(posedge clk or posedge rst) begin : fsm
        if (rst) begin
            state        <= SEARCH;
            good_cnt     <= '0;
            bus.lock     <= 1'b0;
            bus.pix_v    <= 1'b0;
            bus.pix_x    <= '0;
            bus.pix_y    <= '0;
            bus.frame_id <= '0;
        end else begin
            bus.lock  <= lock_nxt;
            bus.pix_v <= lock_nxt & in_win;
            bus.pix_x <= cx - pA'(HBP);
            bus.pix_y <= cy - pA'(VBP);
            unique case (state)
                SEARCH: begin
                    if (vrise) begin
                        state    <= ALIGN;
                        good_cnt <= '0;
                    end
                end
                ALIGN: begin
                    if (err) begin
                        state <= SEARCH;
                    end else if (vrise) begin
                        good_cnt <= good_cnt + GW'(1);
                        if (good_cnt == GW'(LOCK_FRAMES - 1)) state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (err)        state        <= SEARCH;
                    else if (vrise) bus.frame_id <= bus.frame_id + fA'(1);
                end
                default: state <= SEARCH;
            endcase
        end
    end

`ifdef VGA_RX_MEASURE_EN
    // Last observed line/frame length and saturating count of lock losses.
    always_ff @(posedge clk or posedge rst) begin : measure
        if (rst) begin
            bus.meas_hpix   <= '0;
            bus.meas_vlines <= '0;
            bus.err_cnt     <= '0;
        end else begin
            if (hrise) bus.meas_hpix   <= cx + pA'(1);
            if (vrise) bus.meas_vlines <= cy + pA'(1);
            if ((state == LOCKED) && err && (bus.err_cnt != 16'hFFFF))
                bus.err_cnt <= bus.err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver: loopback timing source on a reduced geometry, scoreboarded outputs.
// Measurement checks are active when VGA_RX_MEASURE_EN is defined.
module tb_vga_sync_receiver;
    localparam int PA = 10, FA = 32;
    localparam int H_ACTIVE = 8, HBP = 3, HFP = 2, HPW = 3;
    localparam int V_ACTIVE = 6, VBP = 2, VFP = 1, VPW = 2;
    localparam int LOCK_FRAMES = 2;
    localparam int HTOTAL = H_ACTIVE + HBP + HFP + HPW;
    localparam int VTOTAL = V_ACTIVE + VBP + VFP + VPW;
    localparam int FRAME  = HTOTAL * VTOTAL;

    typedef struct packed {
        logic [PA-1:0] x;
        logic [PA-1:0] y;
        logic          v;
    } pix_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_sync_if #(.pA(PA), .fA(FA)) bus();

    vga_sync_receiver #(
        .pA(PA), .fA(FA),
        .H_ACTIVE(H_ACTIVE), .HBP(HBP), .HFP(HFP), .HPW(HPW),
        .V_ACTIVE(V_ACTIVE), .VBP(VBP), .VFP(VFP), .VPW(VPW),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Timing source: gh=0 is the first back-porch pixel, sync sits at the end of line/frame.
    int   gh = 0, gv = 0;
    int   line_len = HTOTAL, frame_len = VTOTAL;
    logic hs_force = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gh <= 0;
            gv <= 0;
        end else if (gh >= line_len - 1) begin
            gh <= 0;
            gv <= (gv >= frame_len - 1) ? 0 : gv + 1;
        end else begin
            gh <= gh + 1;
        end
    end

    assign bus.hs = hs_force | (gh < HTOTAL - HPW);
    assign bus.vs = (gv < VTOTAL - VPW);

    int           total = 0;
    int           bad = 0;
    pix_t         sb[$];
    logic         locked_exp = 1'b0;
    logic [FA-1:0] exp_fid = '0;

    function automatic pix_t gen_now();
        pix_t p;
        p.x = PA'(gh - HBP);
        p.y = PA'(gv - VBP);
        p.v = (gh >= HBP) && (gh < HBP + H_ACTIVE) && (gv >= VBP) && (gv < VBP + V_ACTIVE);
        return p;
    endfunction

    // One cycle: sample point is the falling edge; queue the source's view of this cycle.
    task automatic tick();
        @(negedge clk);
        sb.push_back(gen_now());
        while (sb.size() > 3) sb.delete(0);
        if (gh == 0 && gv == 0 && locked_exp) exp_fid = exp_fid + FA'(1);
    endtask

    task automatic wait_pos(input int h, input int v, input string name);
        int n = 0;
        while (!(gh == h && gv == v) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        total++;
        if (!(gh == h && gv == v)) begin
            bad++;
            $display("FAIL %s_timeout: got gh=%0d gv=%0d want gh=%0d gv=%0d", name, gh, gv, h, v);
        end
    endtask

    // Lock must appear exactly on the cycle after the (LOCK_FRAMES+1)-th frame start.
    task automatic relock(input string name, output int cycles);
        int seen = 0;
        cycles = 0;
        while (seen < LOCK_FRAMES + 1 && cycles < (LOCK_FRAMES + 2) * FRAME) begin
            tick();
            cycles++;
            if (gh == 0 && gv == 0) seen++;
        end
        total++;
        if (seen != LOCK_FRAMES + 1) begin
            bad++;
            $display("FAIL %s_relock_timeout: got %0d frame starts want %0d", name, seen, LOCK_FRAMES + 1);
        end
        total++;
        if (bus.lock !== 1'b0) begin
            bad++;
            $display("FAIL %s_lock_early: got %0b want 0", name, bus.lock);
        end
        tick();
        total++;
        if (bus.lock !== 1'b1) begin
            bad++;
            $display("FAIL %s_lock_rise: got %0b want 1", name, bus.lock);
        end
        locked_exp = 1'b1;
    endtask

    task automatic test_stream(input string name, input int nframes);
        pix_t exp;
        pix_t got;
        for (int i = 0; i < nframes * FRAME; i++) begin
            tick();
            if (sb.size() == 3) begin
                exp = sb[0];
                sb.delete(0);
                got = {bus.pix_x, bus.pix_y, bus.pix_v};
                total++;
                if (got !== exp) begin
                    bad++;
                    $display("FAIL %s_pix: gh=%0d gv=%0d got x=%0d y=%0d v=%0b want x=%0d y=%0d v=%0b",
                             name, gh, gv, got.x, got.y, got.v, exp.x, exp.y, exp.v);
                end
            end
            total++;
            if (bus.lock !== locked_exp) begin
                bad++;
                $display("FAIL %s_lock: gh=%0d gv=%0d got %0b want %0b", name, gh, gv, bus.lock, locked_exp);
            end
            if (!(gh == 0 && gv == 0)) begin
                total++;
                if (bus.frame_id !== exp_fid) begin
                    bad++;
                    $display("FAIL %s_frame_id: got %0d want %0d", name, bus.frame_id, exp_fid);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.pix_x, bus.pix_y, bus.pix_v, bus.frame_id, bus.lock} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got x=%0d y=%0d v=%0b fid=%0d lock=%0b want all 0",
                     bus.pix_x, bus.pix_y, bus.pix_v, bus.frame_id, bus.lock);
        end
`ifdef VGA_RX_MEASURE_EN
        total++;
        if ({bus.meas_hpix, bus.meas_vlines, bus.err_cnt} !== '0) begin
            bad++;
            $display("FAIL reset_measure: got h=%0d v=%0d err=%0d want all 0",
                     bus.meas_hpix, bus.meas_vlines, bus.err_cnt);
        end
`endif
        sb.delete();
        locked_exp = 1'b0;
        exp_fid    = '0;
        rst        = 1'b0;
    endtask

    task automatic test_loopback();
        int cycles;
        relock("loopback", cycles);
        total++;
        if (cycles != (LOCK_FRAMES + 1) * FRAME) begin
            bad++;
            $display("FAIL loopback_lock_cycle: got %0d want %0d", cycles, (LOCK_FRAMES + 1) * FRAME);
        end
        test_stream("loopback", 2);
    endtask

    task automatic lost_lock(input string name);
        total++;
        if (bus.lock !== 1'b1) begin
            bad++;
            $display("FAIL %s_lock_hold: got %0b want 1", name, bus.lock);
        end
        locked_exp = 1'b0;
        tick();
        total++;
        if ({bus.lock, bus.pix_v} !== 2'b00) begin
            bad++;
            $display("FAIL %s_lock_drop: got lock=%0b pix_v=%0b want 0 0", name, bus.lock, bus.pix_v);
        end
        total++;
        if (bus.frame_id !== exp_fid) begin
            bad++;
            $display("FAIL %s_frame_id_hold: got %0d want %0d", name, bus.frame_id, exp_fid);
        end
    endtask

    task automatic test_missing_hsync();
        int cycles;
        wait_pos(HTOTAL - HPW - 1, 4, "missing_hsync");
        hs_force = 1'b1;
        repeat (HPW + 1) tick();
        hs_force = 1'b0;
        lost_lock("missing_hsync");
        relock("missing_hsync", cycles);
        test_stream("missing_hsync", 1);
    endtask

    task automatic test_short_line();
        int cycles;
        int n = 0;
        wait_pos(1, 4, "short_line");
        line_len = HTOTAL - 1;
        tick();
        while (gh != 0 && n < 2 * HTOTAL) begin
            tick();
            n++;
        end
        line_len = HTOTAL;
        lost_lock("short_line");
        relock("short_line", cycles);
        test_stream("short_line", 1);
    endtask

    task automatic test_short_frame();
        int cycles;
        wait_pos(5, 3, "short_frame");
        frame_len  = VTOTAL - 1;
        locked_exp = 1'b0;
        wait_pos(0, 0, "short_frame_end");
        frame_len  = VTOTAL;
        locked_exp = 1'b1;
        lost_lock("short_frame");
        relock("short_frame", cycles);
        test_stream("short_frame", 1);
    endtask

    task automatic test_measure();
`ifdef VGA_RX_MEASURE_EN
        total++;
        if ({bus.meas_hpix, bus.meas_vlines} !== {PA'(HTOTAL), PA'(VTOTAL)}) begin
            bad++;
            $display("FAIL measure_geometry: got h=%0d v=%0d want h=%0d v=%0d",
                     bus.meas_hpix, bus.meas_vlines, HTOTAL, VTOTAL);
        end
        total++;
        if (bus.err_cnt !== 16'd3) begin
            bad++;
            $display("FAIL measure_err_cnt: got %0d want 3", bus.err_cnt);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        int cycles;
        wait_pos(6, 5, "reset_midframe");
        total++;
        if (bus.pix_v !== 1'b1) begin
            bad++;
            $display("FAIL reset_midframe_active: got pix_v=%0b want 1", bus.pix_v);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.pix_x, bus.pix_y, bus.pix_v, bus.frame_id, bus.lock} !== '0) begin
            bad++;
            $display("FAIL reset_midframe_async: got x=%0d y=%0d v=%0b fid=%0d lock=%0b want all 0",
                     bus.pix_x, bus.pix_y, bus.pix_v, bus.frame_id, bus.lock);
        end
`ifdef VGA_RX_MEASURE_EN
        total++;
        if (bus.err_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_midframe_err_cnt: got %0d want 0", bus.err_cnt);
        end
`endif
        repeat (2) @(negedge clk);
        sb.delete();
        locked_exp = 1'b0;
        exp_fid    = '0;
        rst        = 1'b0;
        relock("reset_midframe", cycles);
        total++;
        if (cycles != (LOCK_FRAMES + 1) * FRAME) begin
            bad++;
            $display("FAIL reset_midframe_lock_cycle: got %0d want %0d", cycles, (LOCK_FRAMES + 1) * FRAME);
        end
        test_stream("reset_midframe", 1);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_missing_hsync();
        test_short_line();
        test_short_frame();
        test_measure();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
